// File: rtl/rv32_mem_pkg.sv
// Shared RV32 data-memory definitions: store size codes, store FSM encoding, lane geometry.
package rv32_mem_pkg;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = 4;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } store_state_e;

endpackage

// File: rtl/store_lane_packer.sv
// Combinational store lane packer: narrows rs2 to the store size, replicates it across
// the four byte lanes and builds the byte strobes; flags misaligned or unknown sizes.
module store_lane_packer
    import rv32_mem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [XLEN-1:0]   data,
    output logic [XLEN-1:0]   wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              fault
);

    // Select replication/strobe pattern by store size; unknown codes fault with no lanes enabled.
    always_comb begin
        wdata = '0;
        wstrb = '0;
        fault = 1'b0;
        case (funct3)
            F3_SB: begin
                wdata = {4{data[7:0]}};
                wstrb = 4'b0001 << off;
            end
            F3_SH: begin
                wdata = {2{data[15:0]}};
                wstrb = 4'b0011 << off;
                fault = off[0];
            end
            F3_SW: begin
                wdata = data;
                wstrb = 4'b1111;
                fault = (off != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_data_packer.sv
// Store data packer: runs one memory write per store with a req/ack handshake.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | waiting for start; lanes packed from live inputs
//  ST_REQ  | mem_req high, address/data/strobes held until mem_ack
//  ST_DONE | one-cycle done pulse; misaligned reports a faulted store
module store_data_packer
    import rv32_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   data,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ack
);

    store_state_e      state;
    logic [XLEN-1:0]   lane_wdata;
    logic [STRB_W-1:0] lane_wstrb;
    logic              lane_fault;

    store_lane_packer u_lane_packer (
        .funct3 (funct3),
        .off    (addr[1:0]),
        .data   (data),
        .wdata  (lane_wdata),
        .wstrb  (lane_wstrb),
        .fault  (lane_fault)
    );

    // Store sequencer; all outputs registered so the memory port sees glitch-free values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (lane_fault) begin
                            // faulted stores skip the memory port entirely
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            state     <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= lane_wdata;
                            mem_wstrb <= lane_wstrb;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    mem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_data_packer.sv
// Directed bench for store_data_packer: hand-computed expectations checked with immediate assertions.
module tb_store_data_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;

    store_data_packer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .funct3     (funct3),
        .addr       (addr),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 time unit so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        funct3 = f3;
        addr   = a;
        data   = d;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        funct3  = 3'b000;
        addr    = '0;
        data    = '0;
        mem_ack = 1'b0;
        step();
        step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
        rst = 1'b0;
        step();

        // SW 0x100, ack raised in cycle 3, done in cycle 4
        issue(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        check("sw_req_c1", {31'b0, mem_req}, 32'd1);
        check("sw_busy_c1", {31'b0, busy}, 32'd1);
        check("sw_addr", mem_addr, 32'h0000_0100);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_wstrb", {28'b0, mem_wstrb}, 32'hF);
        step();
        check("sw_req_c2", {31'b0, mem_req}, 32'd1);
        check("sw_done_c2", {31'b0, done}, 32'd0);
        step();
        check("sw_req_c3", {31'b0, mem_req}, 32'd1);
        check("sw_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sw_done_c4", {31'b0, done}, 32'd1);
        check("sw_mis_c4", {31'b0, misaligned}, 32'd0);
        check("sw_req_c4", {31'b0, mem_req}, 32'd0);
        step();
        check("sw_done_c5", {31'b0, done}, 32'd0);
        check("sw_busy_c5", {31'b0, busy}, 32'd0);

        // SB 0x203 with a competing start while in REQ
        issue(3'b000, 32'h0000_0203, 32'h1234_56AB);
        check("sb_addr", mem_addr, 32'h0000_0200);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_wstrb", {28'b0, mem_wstrb}, 32'h8);
        issue(3'b010, 32'h0000_0400, 32'h5555_5555);
        check("sb_ignored_addr", mem_addr, 32'h0000_0200);
        check("sb_ignored_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_ignored_req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sb_done", {31'b0, done}, 32'd1);
        check("sb_mis", {31'b0, misaligned}, 32'd0);
        step();
        check("sb_idle_busy", {31'b0, busy}, 32'd0);
        step();
        check("sb_no_second_req", {31'b0, mem_req}, 32'd0);
        check("sb_no_second_busy", {31'b0, busy}, 32'd0);

        // SH 0x102, upper half of rs2 discarded
        issue(3'b001, 32'h0000_0102, 32'hFFFF_8001);
        check("sh_wdata", mem_wdata, 32'h8001_8001);
        check("sh_wstrb", {28'b0, mem_wstrb}, 32'hC);
        check("sh_addr", mem_addr, 32'h0000_0100);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sh_done", {31'b0, done}, 32'd1);
        step();

        // SH 0x101 faults: done in cycle 1, no request
        issue(3'b001, 32'h0000_0101, 32'h0000_1111);
        check("shm_done", {31'b0, done}, 32'd1);
        check("shm_mis", {31'b0, misaligned}, 32'd1);
        check("shm_req", {31'b0, mem_req}, 32'd0);
        check("shm_busy", {31'b0, busy}, 32'd1);
        step();
        check("shm_done_clr", {31'b0, done}, 32'd0);
        check("shm_mis_clr", {31'b0, misaligned}, 32'd0);
        check("shm_req_after", {31'b0, mem_req}, 32'd0);

        // invalid funct3 faults
        issue(3'b011, 32'h0000_0000, 32'h0000_0001);
        check("bad_f3_done", {31'b0, done}, 32'd1);
        check("bad_f3_mis", {31'b0, misaligned}, 32'd1);
        check("bad_f3_req", {31'b0, mem_req}, 32'd0);
        step();

        // misaligned SW faults
        issue(3'b010, 32'h0000_0102, 32'h0000_0001);
        check("swm_mis", {31'b0, misaligned}, 32'd1);
        check("swm_req", {31'b0, mem_req}, 32'd0);
        step();

        // reset during REQ abandons the store
        issue(3'b010, 32'h0000_0300, 32'h0123_4567);
        check("rstmid_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_req_clr", {31'b0, mem_req}, 32'd0);
        check("rstmid_no_done", {31'b0, done}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        step();
        check("rstmid_still_no_done", {31'b0, done}, 32'd0);

        // new SW with same-cycle ack on the first request cycle
        issue(3'b010, 32'h0000_0304, 32'hCAFE_F00D);
        check("fast_req", {31'b0, mem_req}, 32'd1);
        check("fast_wdata", mem_wdata, 32'hCAFE_F00D);
        check("fast_addr", mem_addr, 32'h0000_0304);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("fast_done", {31'b0, done}, 32'd1);
        check("fast_req_clr", {31'b0, mem_req}, 32'd0);
        step();

        // stray ack in IDLE changes nothing
        mem_ack = 1'b1;
        step();
        step();
        mem_ack = 1'b0;
        check("stray_busy", {31'b0, busy}, 32'd0);
        check("stray_done", {31'b0, done}, 32'd0);
        check("stray_req", {31'b0, mem_req}, 32'd0);

        // SB lane 1
        issue(3'b000, 32'h0000_0011, 32'h0000_007E);
        check("sb1_wstrb", {28'b0, mem_wstrb}, 32'h2);
        check("sb1_wdata", mem_wdata, 32'h7E7E_7E7E);
        check("sb1_addr", mem_addr, 32'h0000_0010);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sb1_done", {31'b0, done}, 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
